leaderboard_ranked: RTL



---
 rtl/leaderboard_ranked.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/leaderboard_ranked.sv
// rtl/leaderboard_ranked.sv - per-frame score snapshot, stable descending sort, BCD conversion and ranked leaderboard pixel addressing
module leaderboard_ranked #(
  parameter int N_HOUSES      = 4,
  parameter int SCORE_W       = 20,
  parameter int DIGITS        = 6,
  parameter int GLYPH         = 30,
  parameter int PITCH         = 100,
  parameter int TOP           = 40,
  parameter int CREST_COL     = 120,
  parameter int DIGIT_COL     = 280,
  parameter int DIGIT_ROW_OFF = 35
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         leaderboard,
  input  logic                         logo,
  input  logic [8:0]                   row,
  input  logic [9:0]                   col,
  input  logic [N_HOUSES*SCORE_W-1:0]  scores_in,
  output logic [N_HOUSES-1:0]          house,
  output logic                         crest,
  output logic [18:0]                  crest_ADDR,
  output logic                         digit_en,
  output logic [3:0]                   digit_val,
  output logic [12:0]                  score_ADDR,
  output logic                         busy
);

  localparam int IW = (N_HOUSES > 1) ? $clog2(N_HOUSES) : 1;
  localparam int BW = $clog2(SCORE_W);
  localparam int DW = DIGITS * 4;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  if (N_HOUSES < 2 || N_HOUSES > 8) begin : g_chk_houses
    $error("N_HOUSES must be in 2..8");
  end
  if (PITCH * PITCH > (1 << 19)) begin : g_chk_pitch
    $error("PITCH*PITCH exceeds crest_ADDR range");
  end
  if (GLYPH * GLYPH > (1 << 13)) begin : g_chk_glyph
    $error("GLYPH*GLYPH exceeds score_ADDR range");
  end

  typedef enum logic [2:0] {S_IDLE, S_SNAP, S_SORT, S_BCD, S_COMMIT} state_t;
  state_t state, state_n;

  logic [SCORE_W-1:0] snap        [N_HOUSES];
  logic               sat         [N_HOUSES];
  logic [IW-1:0]      work_rank   [N_HOUSES];
  logic [DW-1:0]      work_digits [N_HOUSES];
  logic [IW-1:0]      disp_rank   [N_HOUSES];
  logic [DW-1:0]      disp_digits [N_HOUSES];

  logic [IW-1:0]      sort_j, sort_j1, sort_pass, bcd_slot;
  logic [BW-1:0]      bit_cnt;
  logic [SCORE_W-1:0] bin_sr, cur_bin;
  logic [DW-1:0]      bcd_sr, cur_bcd, adj_bcd, nxt_bcd;
  logic               frame_start, sort_last, bcd_last;

  assign frame_start = leaderboard && (row == 9'd0) && (col == 10'd0);
  assign sort_j1     = sort_j + 1'b1;
  assign sort_last   = (sort_pass == IW'(N_HOUSES - 2)) && (sort_j == IW'(N_HOUSES - 2));
  assign bcd_last    = (bcd_slot == IW'(N_HOUSES - 1)) && (bit_cnt == BW'(SCORE_W - 1));

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (frame_start) state_n = S_SNAP;
      S_SNAP:   state_n = S_SORT;
      S_SORT:   if (sort_last) state_n = S_BCD;
      S_BCD:    if (bcd_last) state_n = S_COMMIT;
      S_COMMIT: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  // One double-dabble step; bit 0 of each slot starts from the snapped score.
  always_comb begin
    cur_bin = (bit_cnt == '0) ? snap[work_rank[bcd_slot]] : bin_sr;
    cur_bcd = (bit_cnt == '0) ? '0 : bcd_sr;
    adj_bcd = cur_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj_bcd[i*4 +: 4] >= 4'd5) adj_bcd[i*4 +: 4] = adj_bcd[i*4 +: 4] + 4'd3;
    end
    nxt_bcd = {adj_bcd[DW-2:0], cur_bin[SCORE_W-1]};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sort_j    <= '0;
      sort_pass <= '0;
      bcd_slot  <= '0;
      bit_cnt   <= '0;
      bin_sr    <= '0;
      bcd_sr    <= '0;
      for (int k = 0; k < N_HOUSES; k++) begin
        disp_rank[k]   <= IW'(k);
        disp_digits[k] <= '0;
      end
    end else begin
      case (state)
        S_SNAP: begin
          for (int k = 0; k < N_HOUSES; k++) begin
            snap[k]      <= scores_in[k*SCORE_W +: SCORE_W];
            sat[k]       <= 64'(scores_in[k*SCORE_W +: SCORE_W]) > MAX_VAL;
            work_rank[k] <= IW'(k);
          end
          sort_j    <= '0;
          sort_pass <= '0;
          bcd_slot  <= '0;
          bit_cnt   <= '0;
        end
        S_SORT: begin
          // Strict compare keeps equal scores in house-index order.
          if (snap[work_rank[sort_j1]] > snap[work_rank[sort_j]]) begin
            work_rank[sort_j]  <= work_rank[sort_j1];
            work_rank[sort_j1] <= work_rank[sort_j];
          end
          if (sort_j == IW'(N_HOUSES - 2)) begin
            sort_j    <= '0;
            sort_pass <= sort_pass + 1'b1;
          end else begin
            sort_j <= sort_j1;
          end
        end
        S_BCD: begin
          bin_sr <= cur_bin << 1;
          bcd_sr <= nxt_bcd;
          if (bit_cnt == BW'(SCORE_W - 1)) begin
            work_digits[bcd_slot] <= sat[work_rank[bcd_slot]] ? {DIGITS{4'd9}} : nxt_bcd;
            bit_cnt  <= '0;
            bcd_slot <= bcd_slot + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_COMMIT: begin
          for (int k = 0; k < N_HOUSES; k++) begin
            disp_rank[k]   <= work_rank[k];
            disp_digits[k] <= work_digits[k];
          end
        end
        default: ;
      endcase
    end
  end

  logic              in_slot, crest_hit, cell_en, nz_seen;
  logic [IW-1:0]     slot;
  int                slot_row, dig_row;
  logic [18:0]       crest_addr_n;
  logic [12:0]       cell_addr;
  logic [3:0]        cell_val, dv;
  logic [DW-1:0]     cur_digits;
  logic [N_HOUSES-1:0] house_n;

  always_comb begin
    in_slot  = 1'b0;
    slot     = '0;
    slot_row = 0;
    for (int k = 0; k < N_HOUSES; k++) begin
      if (int'(row) >= TOP + k*PITCH && int'(row) < TOP + (k+1)*PITCH) begin
        in_slot  = 1'b1;
        slot     = IW'(k);
        slot_row = int'(row) - (TOP + k*PITCH);
      end
    end
    house_n      = (leaderboard && in_slot) ? ({{(N_HOUSES-1){1'b0}}, 1'b1} << disp_rank[slot]) : '0;
    crest_hit    = leaderboard && in_slot && int'(col) >= CREST_COL && int'(col) < CREST_COL + PITCH;
    crest_addr_n = 19'(slot_row*PITCH + (int'(col) - CREST_COL));
    cur_digits   = disp_digits[slot];
    dig_row      = slot_row - DIGIT_ROW_OFF;
    cell_en      = 1'b0;
    cell_val     = '0;
    cell_addr    = '0;
    nz_seen      = 1'b0;
    dv           = '0;
    for (int d = 0; d < DIGITS; d++) begin
      dv      = cur_digits[(DIGITS-1-d)*4 +: 4];
      nz_seen = nz_seen | (dv != 4'd0);
      if (leaderboard && in_slot && dig_row >= 0 && dig_row < GLYPH &&
          int'(col) >= DIGIT_COL + d*GLYPH && int'(col) < DIGIT_COL + (d+1)*GLYPH) begin
        cell_val  = dv;
        cell_en   = nz_seen || (d == DIGITS - 1);
        cell_addr = 13'(dig_row*GLYPH + (int'(col) - DIGIT_COL - d*GLYPH));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      house      <= '0;
      crest      <= 1'b0;
      crest_ADDR <= '0;
      digit_en   <= 1'b0;
      digit_val  <= '0;
      score_ADDR <= '0;
    end else begin
      house      <= house_n;
      crest      <= crest_hit;
      digit_en   <= cell_en;
      digit_val  <= cell_val;
      score_ADDR <= cell_addr;
      if (!logo) crest_ADDR <= crest_hit ? crest_addr_n : '0;
    end
  end

endmodule
